// File: rtl/controlador_memoria_datos_pkg.sv
// -----------------------------------------------------------------------------
// controlador_memoria_datos_pkg
// Definitions shared by the data-memory controller and its RAM:
//   - estado_t : controller FSM state encoding
//   - RW_LEER / RW_ESCRIBIR : meaning of the read/write flag
//   - default data and address widths
// -----------------------------------------------------------------------------
package controlador_memoria_datos_pkg;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,  // idle, ready for a request
    ESPERA   = 3'd1,  // counting wait states
    ACCESO   = 3'd2,  // RAM access happens on the exit edge of this state
    FIN      = 3'd3,  // completion pulse
    LIMPIEZA = 3'd4   // post-reset zero sweep (only with MEM_LIMPIEZA_EN)
  } estado_t;

  localparam logic RW_LEER     = 1'b0;
  localparam logic RW_ESCRIBIR = 1'b1;

  localparam int ANCHO_DATOS_DEF = 8;
  localparam int ANCHO_DIREC_DEF = 8;

endpackage

// File: rtl/controlador_memoria_datos_ram.sv
// -----------------------------------------------------------------------------
// ram_datos_1p
// Synchronous single-port RAM with registered read data.
//   clk   : clock, rising edge
//   we    : write enable, writes wdata to mem[addr]
//   addr  : word address (must be below PROFUNDIDAD when used)
//   wdata : write data
//   rdata : mem[addr] as seen at the previous rising edge (read-before-write)
// -----------------------------------------------------------------------------
module ram_datos_1p #(
  parameter int ANCHO_DATOS = 8,
  parameter int ANCHO_DIREC = 8,
  parameter int PROFUNDIDAD = 256
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ANCHO_DIREC-1:0] addr,
  input  logic [ANCHO_DATOS-1:0] wdata,
  output logic [ANCHO_DATOS-1:0] rdata
);

  logic [ANCHO_DATOS-1:0] mem [PROFUNDIDAD];

  // NOTE: the array and its read register carry no reset so the storage maps
  // onto block RAM; zeroing, when wanted, is done by the controller's sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/controlador_memoria_datos.sv
// -----------------------------------------------------------------------------
// controlador_memoria_datos
// Data-memory stage: accepts one read/write request at a time through a
// valid/ready handshake, spends CICLOS_ESPERA wait states, accesses an
// internal single-port RAM and reports completion with a one-cycle pulse.
//
// Ports:
//   i_Clk             : clock, rising edge
//   i_Reset           : asynchronous, active-high reset
//   i_Valido          : request strobe, taken only while o_Listo=1
//   i_Direccion_Datos : data address
//   i_Salida_Datos    : byte to write
//   i_RW              : 1 = write, 0 = read
//   o_Listo           : ready to accept a request
//   o_Hecho           : one-cycle completion pulse
//   o_Dato_Leido      : registered read data, held until the next read
//   o_Error           : pulses with o_Hecho when the address is out of range
//
// Build option: MEM_LIMPIEZA_EN -- when defined, reset release runs a
// LIMPIEZA sweep that writes zero to every RAM word before becoming ready.
// -----------------------------------------------------------------------------
module controlador_memoria_datos
  import controlador_memoria_datos_pkg::*;
#(
  parameter int ANCHO_DATOS   = ANCHO_DATOS_DEF,
  parameter int ANCHO_DIREC   = ANCHO_DIREC_DEF,
  parameter int PROFUNDIDAD   = 256,
  parameter int CICLOS_ESPERA = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Valido,
  input  logic [ANCHO_DIREC-1:0] i_Direccion_Datos,
  input  logic [ANCHO_DATOS-1:0] i_Salida_Datos,
  input  logic                   i_RW,
  output logic                   o_Listo,
  output logic                   o_Hecho,
  output logic [ANCHO_DATOS-1:0] o_Dato_Leido,
  output logic                   o_Error
);

  // Range limit widened by one bit so PROFUNDIDAD = 2^ANCHO_DIREC is representable.
  localparam logic [ANCHO_DIREC:0]   LIMITE = (ANCHO_DIREC+1)'(PROFUNDIDAD);
  localparam logic [3:0]             ULTIMA_ESPERA = 4'(CICLOS_ESPERA - 1);

`ifdef MEM_LIMPIEZA_EN
  localparam estado_t                ESTADO_RST = LIMPIEZA;
  localparam logic                   LISTO_RST  = 1'b0;
  localparam logic [ANCHO_DIREC-1:0] ULTIMA_DIR = ANCHO_DIREC'(PROFUNDIDAD - 1);
  logic [ANCHO_DIREC-1:0]            barrido;
`else
  localparam estado_t                ESTADO_RST = REPOSO;
  localparam logic                   LISTO_RST  = 1'b1;
`endif

  estado_t                estado;
  logic [3:0]             cuenta;
  logic [ANCHO_DIREC-1:0] dir_q;
  logic [ANCHO_DATOS-1:0] dato_q;
  logic                   rw_q;
  logic                   en_rango;

  logic                   ram_we;
  logic [ANCHO_DIREC-1:0] ram_addr;
  logic [ANCHO_DATOS-1:0] ram_wdata;
  logic [ANCHO_DATOS-1:0] ram_rdata;

  assign en_rango = {1'b0, dir_q} < LIMITE;

  // While idle the RAM reads the incoming address, so the word is already in
  // the RAM's read register by ACCESO even with zero wait states. Afterwards
  // it keeps reading the latched address. The write strobe depends only on
  // the state, so a reset before the ACCESO exit edge can never write.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which is what keeps combinational logic free of latches.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = dir_q;
    ram_wdata = dato_q;
    if (estado == REPOSO) begin
      ram_addr = i_Direccion_Datos;
    end
    if (estado == ACCESO && rw_q == RW_ESCRIBIR && en_rango) begin
      ram_we = 1'b1;
    end
`ifdef MEM_LIMPIEZA_EN
    if (estado == LIMPIEZA) begin
      ram_we    = 1'b1;
      ram_addr  = barrido;
      ram_wdata = '0;
    end
`endif
  end

  ram_datos_1p #(
    .ANCHO_DATOS (ANCHO_DATOS),
    .ANCHO_DIREC (ANCHO_DIREC),
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_ram (
    .clk   (i_Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      estado       <= ESTADO_RST;
      cuenta       <= '0;
      dir_q        <= '0;
      dato_q       <= '0;
      rw_q         <= RW_LEER;
      o_Listo      <= LISTO_RST;
      o_Hecho      <= 1'b0;
      o_Dato_Leido <= '0;
      o_Error      <= 1'b0;
`ifdef MEM_LIMPIEZA_EN
      barrido      <= '0;
`endif
    end else begin
      o_Hecho <= 1'b0;
      o_Error <= 1'b0;
      case (estado)
        REPOSO: begin
          if (i_Valido) begin
            dir_q   <= i_Direccion_Datos;
            dato_q  <= i_Salida_Datos;
            rw_q    <= i_RW;
            cuenta  <= '0;
            o_Listo <= 1'b0;
            estado  <= (CICLOS_ESPERA > 0) ? ESPERA : ACCESO;
          end
        end
        ESPERA: begin
          cuenta <= cuenta + 4'd1;
          if (cuenta == ULTIMA_ESPERA) begin
            estado <= ACCESO;
          end
        end
        ACCESO: begin
          if (rw_q == RW_LEER) begin
            o_Dato_Leido <= en_rango ? ram_rdata : '0;
          end
          o_Hecho <= 1'b1;
          o_Error <= ~en_rango;
          estado  <= FIN;
        end
        FIN: begin
          o_Listo <= 1'b1;
          estado  <= REPOSO;
        end
`ifdef MEM_LIMPIEZA_EN
        LIMPIEZA: begin
          barrido <= barrido + 1'b1;
          if (barrido == ULTIMA_DIR) begin
            o_Listo <= 1'b1;
            estado  <= REPOSO;
          end
        end
`endif
        default: begin
          o_Listo <= 1'b1;
          estado  <= REPOSO;
        end
      endcase
    end
  end

endmodule
